poseidon_sbox: RTL and testbench
================================

POSEIDON_SBOX -- requirements
Module: poseidon_sbox

Interface
REQ-001 SHALL have parameter DW, default 256, giving the field-element width of i_x, i_p and o_y.
REQ-002 SHALL have parameter MDW, default DW+2, giving the internal accumulator width that holds values below 4p without overflow.
REQ-003 i_clk  input  1  clock; all state updates on rising edge.
REQ-004 i_rstn  input  1  reset, asynchronous, active-low.
REQ-005 i_en  input  1  start strobe; driven by the upstream addroundconstant o_flag.
REQ-006 i_x  input  DW  S-box operand, the upstream o_arc value; legal range 0 <= i_x < 2p.
REQ-007 i_p  input  DW  field modulus; legal range p > 1.
REQ-008 o_y  output  DW  result, i_x^5 mod p.
REQ-009 o_flag  output  1  one-cycle result-valid pulse.
REQ-010 o_busy  output  1  high while the block is not idle.

Function
REQ-011 SHALL implement the FSM states IDLE, SQ1, SQ2, MUL and DONE, with o_busy = (state != IDLE).
REQ-012 IDLE: i_en=1 at edge E0 SHALL latch p, latch x' = (i_x >= p) ? i_x-p : i_x, and move to SQ1.
REQ-013 i_en while state != IDLE SHALL be ignored, with no queuing and no corruption of the running operation.
REQ-014 Each multiply a*b mod p SHALL be bit-serial interleaved, MSB-first over DW cycles, using a DW-1..0 counter.
REQ-015 Each multiply step SHALL compute acc <= 2*acc + (a[i] ? b : 0), then subtract p up to twice so that acc < p afterwards.
REQ-016 SQ1 SHALL compute t2 = x'*x' in edges E0+1..E0+DW, then move to SQ2.
REQ-017 SQ2 SHALL compute t4 = t2*t2 in edges E0+DW+1..E0+2DW, then move to MUL.
REQ-018 MUL SHALL compute t5 = t4*x' in edges E0+2DW+1..E0+3DW, then move to DONE.
REQ-019 At the DONE edge E0+3DW+1 the block SHALL set o_y <= t5 and o_flag <= 1, and return to IDLE.
REQ-020 o_flag SHALL be high exactly one cycle, low from edge E0+3DW+2.
REQ-021 Total latency SHALL be 3*DW+1 cycles from the accepting edge to o_flag, with throughput of one operation per 3*DW+2 cycles.
REQ-022 o_y SHALL hold its last value until the next DONE; it SHALL change only at DONE.
REQ-023 i_en=1 in the same cycle the block returns to IDLE (the o_flag cycle) SHALL be accepted at the next edge.
REQ-024 Operand x=0 SHALL yield 0, and x=p SHALL reduce to 0 and yield 0.
REQ-025 Internal subtractions SHALL use MDW-bit arithmetic; the accumulator SHALL never wrap.
REQ-026 i_x and i_p SHALL be sampled only at acceptance; later input changes SHALL have no effect on a running operation.

Reset
REQ-027 While i_rstn=0 the block SHALL hold state=IDLE, o_y=0, o_flag=0, o_busy=0, and clear the accumulator, operands and counter.
REQ-028 Reset asserted mid-operation SHALL abort immediately with no o_flag; after release the block SHALL accept a new i_en on the first edge.

Configuration
REQ-029 Macro POSEIDON_SBOX_PARTIAL_EN defined SHALL add the port i_partial (input, 1 bit), sampled with i_en.
REQ-030 With POSEIDON_SBOX_PARTIAL_EN defined and i_partial=1 at acceptance, the block SHALL skip SQ1, SQ2 and MUL (IDLE->DONE) and output o_y=x' with o_flag at edge E0+1, serving partial-round lanes.
REQ-031 With POSEIDON_SBOX_PARTIAL_EN defined and i_partial=0, behaviour SHALL be identical to REQ-011..REQ-026.
REQ-032 With POSEIDON_SBOX_PARTIAL_EN undefined, i_partial SHALL be absent and every operation SHALL be a full x^5.

Verification
REQ-033 i_x=3, i_p=7, single i_en pulse -> o_y=5, o_flag one cycle exactly 3*DW+1 cycles after acceptance, o_busy low afterwards.
REQ-034 i_x=p-1 with p=2^255-19 -> o_y=p-1; i_x=0 -> o_y=0; i_x=p+2 -> o_y=32.
REQ-035 i_en pulses at E0+5 and E0+2DW while busy -> only one o_flag; o_y matches the first operand.
REQ-036 i_en held high continuously, i_x=2, p=11 -> results 10 each time, o_flag spaced exactly 3*DW+2 cycles apart.
REQ-037 i_rstn low at E0+100 for 3 cycles -> no o_flag, all outputs 0; new op i_x=4, p=13 after release -> o_y=10.
REQ-038 With POSEIDON_SBOX_PARTIAL_EN defined: i_partial=1, i_x=9, p=7 -> o_y=2 with o_flag at E0+1; i_partial=0, same inputs -> o_y=4 at E0+3DW+1.

Source files
------------

// File: rtl/poseidon_sbox_if.sv
// Bus bundle for the Poseidon x^5 S-box: start strobe, operand, modulus and result.
// Optional build macro: POSEIDON_SBOX_PARTIAL_EN adds the i_partial bypass request.
interface poseidon_sbox_if #(
  parameter int unsigned DW = 256
);
  logic          i_en;
  logic [DW-1:0] i_x;
  logic [DW-1:0] i_p;
`ifdef POSEIDON_SBOX_PARTIAL_EN
  logic          i_partial;
`endif
  logic [DW-1:0] o_y;
  logic          o_flag;
  logic          o_busy;

  // Upstream side drives the operands, sees the result
  modport master (
`ifdef POSEIDON_SBOX_PARTIAL_EN
    output i_partial,
`endif
    output i_en, i_x, i_p,
    input  o_y, o_flag, o_busy
  );

  // S-box side consumes the operands, drives the result
  modport slave (
`ifdef POSEIDON_SBOX_PARTIAL_EN
    input  i_partial,
`endif
    input  i_en, i_x, i_p,
    output o_y, o_flag, o_busy
  );
endinterface

// File: rtl/poseidon_sbox.sv
// Poseidon S-box: y = x^5 mod p via three bit-serial interleaved modular
// multiplies (x^2, x^4, x^4*x), MSB-first, one operand bit per cycle.
// Optional build macro: POSEIDON_SBOX_PARTIAL_EN -- i_partial=1 at acceptance
// bypasses the exponentiation and returns the reduced operand after one cycle.
module poseidon_sbox #(
  parameter int unsigned DW  = 256,
  parameter int unsigned MDW = DW + 2
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  poseidon_sbox_if.slave   io_bus
);

  localparam int unsigned CW = $clog2(DW);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SQ1  = 3'd1,
    SQ2  = 3'd2,
    MUL  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_nstate;

  logic [DW-1:0]   r_p;
  logic [DW-1:0]   r_x;
  logic [DW-1:0]   r_a;
  logic [DW-1:0]   r_b;
  logic [MDW-1:0]  r_acc;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_y;
  logic            r_flag;

  logic            w_partial;
  logic            w_accept;
  logic            w_step;
  logic            w_last;
  logic            w_done;
  logic [DW-1:0]   w_xr;
  logic [MDW-1:0]  w_pm;
  logic [MDW-1:0]  w_sum;
  logic [MDW-1:0]  w_s1;
  logic [MDW-1:0]  w_s2;
  logic [DW-1:0]   w_res;

`ifdef POSEIDON_SBOX_PARTIAL_EN
  assign w_partial = io_bus.i_partial;
`else
  assign w_partial = 1'b0;
`endif

  // Operand pre-reduction: legal inputs are below 2p, so one subtraction suffices
  assign w_xr = (io_bus.i_x >= io_bus.i_p) ? (io_bus.i_x - io_bus.i_p) : io_bus.i_x;

  // One interleaved step: acc < p and b < p keep 2*acc + b below 3p, two
  // conditional subtractions bring it back under p without wrapping MDW bits
  always_comb begin
    w_pm  = MDW'(r_p);
    w_sum = (r_acc << 1) + (r_a[r_cnt] ? MDW'(r_b) : MDW'(0));
    w_s1  = (w_sum >= w_pm) ? (w_sum - w_pm) : w_sum;
    w_s2  = (w_s1 >= w_pm) ? (w_s1 - w_pm) : w_s1;
    w_res = DW'(w_s2);
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= IDLE;
    else         r_state <= w_nstate;
  end

  // Next-state: each multiply phase ends when the bit counter reaches zero
  always_comb begin
    w_nstate = r_state;
    case (r_state)
      IDLE:    if (io_bus.i_en) w_nstate = w_partial ? DONE : SQ1;
      SQ1:     if (r_cnt == '0) w_nstate = SQ2;
      SQ2:     if (r_cnt == '0) w_nstate = MUL;
      MUL:     if (r_cnt == '0) w_nstate = DONE;
      DONE:    w_nstate = IDLE;
      default: w_nstate = IDLE;
    endcase
  end

  // Control decode for the datapath and result registers
  always_comb begin
    w_accept = 1'b0;
    w_step   = 1'b0;
    w_last   = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      IDLE:          w_accept = io_bus.i_en;
      SQ1, SQ2, MUL: begin
        w_step = 1'b1;
        w_last = (r_cnt == '0);
      end
      DONE:          w_done = 1'b1;
      default:       ;
    endcase
  end

  // Datapath: latch operands on acceptance, then chain x^2 -> x^4 -> x^5
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_p   <= '0;
      r_x   <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_p   <= io_bus.i_p;
      r_x   <= w_xr;
      r_a   <= w_xr;
      r_b   <= w_xr;
      r_acc <= w_partial ? MDW'(w_xr) : '0;
      r_cnt <= CW'(DW - 1);
    end else if (w_step) begin
      if (w_last) begin
        r_cnt <= CW'(DW - 1);
        case (r_state)
          SQ1: begin
            r_a   <= w_res;
            r_b   <= w_res;
            r_acc <= '0;
          end
          SQ2: begin
            r_a   <= w_res;
            r_b   <= r_x;
            r_acc <= '0;
          end
          default: r_acc <= w_s2;
        endcase
      end else begin
        r_cnt <= r_cnt - CW'(1);
        r_acc <= w_s2;
      end
    end
  end

  // Result registers: o_y changes only at DONE, o_flag is a one-cycle pulse
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_y    <= '0;
      r_flag <= 1'b0;
    end else begin
      r_flag <= w_done;
      if (w_done) r_y <= DW'(r_acc);
    end
  end

  assign io_bus.o_y    = r_y;
  assign io_bus.o_flag = r_flag;
  assign io_bus.o_busy = (r_state != IDLE);

endmodule

// File: tb/tb_poseidon_sbox.sv
// Directed bench for poseidon_sbox at DW=256 with hand-computed x^5 mod p vectors.
// Optional build macro: POSEIDON_SBOX_PARTIAL_EN enables the bypass vectors.
module tb_poseidon_sbox;
  localparam int unsigned DW  = 256;
  localparam int unsigned LAT = 3 * DW + 1;

  logic clk;
  logic rstn;
  int   n_total;
  int   n_pass;

  poseidon_sbox_if #(.DW(DW)) bus ();

  poseidon_sbox #(.DW(DW)) u_dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single operation: accept, scramble inputs, time the flag, check result and idle
  task automatic run_op(input logic [DW-1:0] x, input logic [DW-1:0] p,
                        input logic [DW-1:0] exp, input string tag);
    int n;
    bit seen;
    bus.i_x  = x;
    bus.i_p  = p;
    bus.i_en = 1'b1;
    tick();
    bus.i_en = 1'b0;
    bus.i_x  = ~x;
    bus.i_p  = '1;
    chk({tag, "_busy"}, DW'(bus.o_busy), DW'(1));
    n    = 0;
    seen = 1'b0;
    while (!seen && n < LAT + 10) begin
      tick();
      n++;
      if (bus.o_flag) seen = 1'b1;
    end
    chk({tag, "_lat"}, DW'(n), DW'(LAT));
    chk({tag, "_y"}, bus.o_y, exp);
    tick();
    chk({tag, "_flag_low"}, DW'(bus.o_flag), DW'(0));
    chk({tag, "_idle"}, DW'(bus.o_busy), DW'(0));
    chk({tag, "_y_hold"}, bus.o_y, exp);
  endtask

  logic [DW-1:0] p25519;
  logic [DW-1:0] v;
  int            flags;
  int            first_at;
  int            last_at;
  int            n;

  initial begin
    n_total  = 0;
    n_pass   = 0;
    bus.i_en = 1'b0;
    bus.i_x  = '0;
    bus.i_p  = '0;
`ifdef POSEIDON_SBOX_PARTIAL_EN
    bus.i_partial = 1'b0;
`endif
    rstn = 1'b0;
    p25519 = (DW'(1) << 255) - DW'(19);

    // Reset state
    tick();
    tick();
    chk("rst_y", bus.o_y, '0);
    chk("rst_flag", DW'(bus.o_flag), DW'(0));
    chk("rst_busy", DW'(bus.o_busy), DW'(0));
    rstn = 1'b1;

    // Small-field and 2^255-19 vectors
    run_op(DW'(3), DW'(7), DW'(5), "x3p7");
    run_op(DW'(6), DW'(7), DW'(6), "x6p7");
    run_op(DW'(10), DW'(13), DW'(4), "x10p13");
    run_op(p25519 - DW'(1), p25519, p25519 - DW'(1), "pm1");
    run_op(DW'(0), p25519, DW'(0), "zero");
    run_op(p25519, p25519, DW'(0), "x_eq_p");
    run_op(p25519 + DW'(2), p25519, DW'(32), "pp2");
    run_op(DW'(1) << 51, p25519, DW'(19), "x2e51");
    run_op(DW'(1) << 52, p25519, DW'(608), "x2e52");

    // Strobes while busy are ignored
    bus.i_x  = DW'(3);
    bus.i_p  = DW'(7);
    bus.i_en = 1'b1;
    tick();
    bus.i_en = 1'b0;
    flags    = 0;
    first_at = 0;
    for (int c = 1; c <= 2 * (LAT + 1); c++) begin
      if (c == 5 || c == 2 * DW) begin
        bus.i_en = 1'b1;
        bus.i_x  = DW'(6);
        bus.i_p  = DW'(11);
      end
      tick();
      bus.i_en = 1'b0;
      if (bus.o_flag) begin
        flags++;
        if (first_at == 0) first_at = c;
      end
    end
    chk("busy_ign_flags", DW'(flags), DW'(1));
    chk("busy_ign_lat", DW'(first_at), DW'(LAT));
    chk("busy_ign_y", bus.o_y, DW'(5));

    // Continuous strobe: back-to-back results spaced 3*DW+2 apart
    bus.i_x  = DW'(2);
    bus.i_p  = DW'(11);
    bus.i_en = 1'b1;
    tick();
    flags   = 0;
    last_at = 0;
    n       = 0;
    while (flags < 3 && n < 4 * (LAT + 1)) begin
      tick();
      n++;
      if (bus.o_flag) begin
        flags++;
        chk($sformatf("cont_y%0d", flags), bus.o_y, DW'(10));
        if (flags == 1) chk("cont_lat", DW'(n), DW'(LAT));
        else chk($sformatf("cont_gap%0d", flags), DW'(n - last_at), DW'(LAT + 1));
        last_at = n;
      end
    end
    bus.i_en = 1'b0;
    chk("cont_count", DW'(flags), DW'(3));
    tick();
    chk("cont_idle", DW'(bus.o_busy), DW'(0));

    // Reset mid-operation aborts with no flag
    bus.i_x  = DW'(3);
    bus.i_p  = DW'(7);
    bus.i_en = 1'b1;
    tick();
    bus.i_en = 1'b0;
    flags    = 0;
    for (int c = 1; c < 100; c++) begin
      tick();
      if (bus.o_flag) flags++;
    end
    rstn = 1'b0;
    #1;
    chk("abort_busy_now", DW'(bus.o_busy), DW'(0));
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.o_flag) flags++;
      chk($sformatf("abort_y%0d", c), bus.o_y, '0);
    end
    chk("abort_busy", DW'(bus.o_busy), DW'(0));
    rstn = 1'b1;
    for (int c = 0; c < LAT; c++) begin
      if (c > 0) tick();
      if (bus.o_flag) flags++;
      if (c == 0) break;
    end
    chk("abort_noflag", DW'(flags), DW'(0));
    run_op(DW'(4), DW'(13), DW'(10), "post_rst");

`ifdef POSEIDON_SBOX_PARTIAL_EN
    // Bypass lane returns the reduced operand one cycle after acceptance
    bus.i_partial = 1'b1;
    bus.i_x  = DW'(9);
    bus.i_p  = DW'(7);
    bus.i_en = 1'b1;
    tick();
    bus.i_en = 1'b0;
    bus.i_partial = 1'b0;
    tick();
    chk("part_flag", DW'(bus.o_flag), DW'(1));
    chk("part_y", bus.o_y, DW'(2));
    tick();
    chk("part_flag_low", DW'(bus.o_flag), DW'(0));
    run_op(DW'(9), DW'(7), DW'(4), "part_off");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
